// File: rtl/pmem_arbiter.sv
// ---------------------------------------------------------------------------
// pmem_arbiter
//   Shares one cacheline-wide physical memory port between the I-cache
//   line-fill path and the D-cache fill/writeback path. One requester is
//   granted at a time. The winner's address and line are registered for the
//   whole transaction. Read data and the completion pulse go back only to the
//   granted side.
//
//   Ports
//     clk, rst                        clock; asynchronous active-low reset
//     i_pmem_read / i_pmem_address    I-cache fill request (level) + address
//     i_pmem_rdata / i_pmem_resp      fill line + one-cycle completion to I
//     d_pmem_read / d_pmem_write      D-cache fill / writeback request (level)
//     d_pmem_address / d_pmem_wdata   D-cache address + writeback line
//     d_pmem_rdata / d_pmem_resp      fill line + one-cycle completion to D
//     mem_read / mem_write            request to memory, held until mem_resp
//     mem_address / mem_wdata         registered address / line of the grant
//     mem_rdata / mem_resp            memory return line + completion pulse
// ---------------------------------------------------------------------------
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE_I = 2'd1,
        S_SERVE_D = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_d;   // 1: most recent grant went to D
    logic              r_d_wr;     // D transaction kind, frozen at grant
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

    // Arbitration happens only in IDLE. On a tie the side that did not win
    // last time goes first, so neither cache can starve the other.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_i_req && w_d_req) begin
                w_grant_d = ~r_last_d;
                w_grant_i = r_last_d;
            end else begin
                w_grant_i = w_i_req;
                w_grant_d = w_d_req;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_i)      w_next = S_SERVE_I;
                else if (w_grant_d) w_next = S_SERVE_D;
            end
            S_SERVE_I: if (mem_resp) w_next = S_RELEASE;
            S_SERVE_D: if (mem_resp) w_next = S_RELEASE;
            // One dead cycle gives the served cache time to drop its level
            // request before the next arbitration looks at it.
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output logic. The memory request is decoded from the registered
    // state, so it starts the cycle after the grant edge and drops the
    // instant reset is asserted.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (r_state)
            S_SERVE_I: begin
                mem_read    = 1'b1;
                i_pmem_resp = mem_resp;
            end
            S_SERVE_D: begin
                mem_read    = ~r_d_wr;
                mem_write   = r_d_wr;
                d_pmem_resp = mem_resp;
            end
            default: ;
        endcase
    end

    // Return data is gated so the non-granted side never sees a live line.
    assign i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;
    assign d_pmem_rdata = d_pmem_resp ? mem_rdata : '0;

    // Grant capture. A D request with both read and write high is a
    // writeback; its read half is not served separately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d <= 1'b0;
            r_d_wr   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_grant_i) begin
            r_last_d <= 1'b0;
            r_addr   <= i_pmem_address;
        end else if (w_grant_d) begin
            r_last_d <= 1'b1;
            r_d_wr   <= d_pmem_write;
            r_addr   <= d_pmem_address;
            r_wdata  <= d_pmem_wdata;
        end
    end

    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;

    a_no_rw_both : assert property (@(posedge clk) disable iff (!rst)
        !(mem_read && mem_write));
    a_one_resp : assert property (@(posedge clk) disable iff (!rst)
        !(i_pmem_resp && d_pmem_resp));

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } dreq_t;

    typedef struct {
        logic         ir;
        logic         dr;
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] rdata;
        int           cyc;
        int           gap;
    } obs_t;

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    pmem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // memory model controls
    int mem_lat = 5;
    bit use_a5 = 0;
    int busy_cnt = 0;

    // requester agent state: tests push, bench_cycle advances heads
    logic [31:0] i_q[$];
    dreq_t       d_q[$];
    int i_head = 0;
    int d_head = 0;
    bit i_drop = 0;
    bit scramble = 0;

    // monitor results
    obs_t obs[$];
    int cur_cyc = 0, idle_gap = 0, rd_cyc = 0;
    int stab_err = 0, both_err = 0, both_resp_err = 0, spurious = 0;
    logic [31:0]  cur_addr;
    logic [255:0] cur_wdata;

    // reference model
    exp_t exp_q[$];
    bit   exp_last_d = 0;

    function automatic logic [255:0] line_of(logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(k + 1));
        return l;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // memory responder: mem_resp after mem_lat cycles of a held request
    initial begin : responder
        mem_resp = 0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_resp) begin
                mem_resp = 0;
                mem_rdata = '0;
                busy_cnt = 0;
            end else if (mem_read || mem_write) begin
                busy_cnt++;
                if (busy_cnt >= mem_lat) begin
                    mem_resp = 1;
                    mem_rdata = use_a5 ? {32{8'hA5}} : line_of(mem_address);
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // per-cycle monitor followed by the two cache agents
    initial begin : bench_cycle
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                cur_cyc = 0;
            end else begin
                if (mem_read && mem_write) both_err++;
                if (i_pmem_resp && d_pmem_resp) both_resp_err++;
                if ((i_pmem_resp || d_pmem_resp) && !mem_resp) spurious++;
                if (mem_read) rd_cyc++;
                if (mem_read || mem_write) begin
                    if (cur_cyc == 0) begin
                        cur_addr = mem_address;
                        cur_wdata = mem_wdata;
                    end else if (mem_address !== cur_addr || mem_wdata !== cur_wdata) begin
                        stab_err++;
                    end
                    cur_cyc++;
                end else begin
                    cur_cyc = 0;
                    idle_gap++;
                end
                if (i_pmem_resp || d_pmem_resp) begin
                    obs_t o;
                    o.ir = i_pmem_resp; o.dr = d_pmem_resp;
                    o.rd = mem_read; o.wr = mem_write;
                    o.addr = mem_address; o.wdata = mem_wdata;
                    o.rdata = i_pmem_resp ? i_pmem_rdata : d_pmem_rdata;
                    o.cyc = cur_cyc; o.gap = idle_gap;
                    obs.push_back(o);
                    cur_cyc = 0;
                    idle_gap = 0;
                end
            end
            if (i_drop) i_head = i_q.size();
            if (i_pmem_resp && i_head < i_q.size()) i_head++;
            if (d_pmem_resp && d_head < d_q.size()) d_head++;
            if (i_head < i_q.size()) begin
                i_pmem_read = 1;
                i_pmem_address = i_q[i_head];
            end else begin
                i_pmem_read = 0;
                i_pmem_address = $urandom;
            end
            if (d_head < d_q.size()) begin
                d_pmem_read = d_q[d_head].rd;
                d_pmem_write = d_q[d_head].wr;
                if (scramble && (mem_read || mem_write) && !d_pmem_resp) begin
                    d_pmem_address = $urandom;
                    d_pmem_wdata = rand_line();
                end else begin
                    d_pmem_address = d_q[d_head].addr;
                    d_pmem_wdata = d_q[d_head].wdata;
                end
            end else begin
                d_pmem_read = 0;
                d_pmem_write = 0;
                d_pmem_address = $urandom;
                d_pmem_wdata = rand_line();
            end
        end
    end

    // Service order from the arbitration rules, assuming every queued
    // request is presented at once and re-presented right after each resp.
    task automatic predict();
        int ii = i_head;
        int di = d_head;
        exp_q.delete();
        while (ii < i_q.size() || di < d_q.size()) begin
            exp_t e;
            bit pick_d;
            if (ii < i_q.size() && di < d_q.size()) pick_d = !exp_last_d;
            else pick_d = (di < d_q.size());
            e.is_d = pick_d;
            if (pick_d) begin
                e.wr = d_q[di].wr; e.addr = d_q[di].addr; e.wdata = d_q[di].wdata; di++;
            end else begin
                e.wr = 0; e.addr = i_q[ii]; e.wdata = '0; ii++;
            end
            exp_q.push_back(e);
            exp_last_d = pick_d;
        end
    endtask

    task automatic drain(input int budget, output bit ok);
        int n = 0;
        while ((i_head < i_q.size() || d_head < d_q.size()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = !(i_head < i_q.size() || d_head < d_q.size());
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got rd/wr/iresp/dresp=%b want 0000",
                     {mem_read, mem_write, i_pmem_resp, d_pmem_resp});
        end
        n_cmp++;
        if (mem_address !== 32'h0) begin
            n_err++; $display("FAIL reset_addr got %h want 0", mem_address);
        end
        n_cmp++;
        if (mem_wdata !== 256'h0) begin
            n_err++; $display("FAIL reset_wdata got %h want 0", mem_wdata);
        end
        @(negedge clk);
        #3 rst = 1;
        exp_last_d = 0;
    endtask

    task automatic test_i_only();
        int start = obs.size();
        int rd0 = rd_cyc;
        bit ok;
        logic [255:0] a5 = {32{8'hA5}};
        use_a5 = 1;
        mem_lat = 5;
        i_q.push_back(32'h0000_0060);
        predict();
        drain(200, ok);
        use_a5 = 0;
        n_cmp++;
        if (!ok || obs.size() - start != 1) begin
            n_err++; $display("FAIL ionly_count got %0d resp (done=%0b) want 1", obs.size() - start, ok);
        end else begin
            obs_t o = obs[start];
            n_cmp++;
            if (o.ir !== 1'b1 || o.dr !== 1'b0 || o.rd !== 1'b1 || o.wr !== 1'b0) begin
                n_err++; $display("FAIL ionly_side got ir=%b dr=%b rd=%b wr=%b want 1 0 1 0", o.ir, o.dr, o.rd, o.wr);
            end
            n_cmp++;
            if (o.addr !== 32'h60) begin
                n_err++; $display("FAIL ionly_addr got %h want 00000060", o.addr);
            end
            n_cmp++;
            if (o.rdata !== a5) begin
                n_err++; $display("FAIL ionly_rdata got %h want %h", o.rdata, a5);
            end
            n_cmp++;
            if (o.cyc != 5 || rd_cyc - rd0 != 5) begin
                n_err++; $display("FAIL ionly_len got %0d/%0d read cycles want 5", o.cyc, rd_cyc - rd0);
            end
        end
    endtask

    task automatic test_simultaneous();
        int start = obs.size();
        bit ok;
        dreq_t d;
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        #3 rst = 1;
        exp_last_d = 0;
        mem_lat = 3;
        d.rd = 0; d.wr = 1; d.addr = 32'h0000_0200; d.wdata = rand_line();
        @(negedge clk);
        i_q.push_back(32'h0000_0100);
        d_q.push_back(d);
        predict();
        drain(300, ok);
        n_cmp++;
        if (!ok || obs.size() - start != exp_q.size()) begin
            n_err++; $display("FAIL simul_count got %0d want %0d (done=%0b)", obs.size() - start, exp_q.size(), ok);
        end
        foreach (exp_q[k]) if (start + k < obs.size()) begin
            obs_t o = obs[start + k];
            n_cmp++;
            if (o.dr !== exp_q[k].is_d || o.ir === exp_q[k].is_d || o.wr !== exp_q[k].wr ||
                o.rd === exp_q[k].wr || o.addr !== exp_q[k].addr ||
                (exp_q[k].wr ? o.wdata !== exp_q[k].wdata : o.rdata !== line_of(exp_q[k].addr))) begin
                n_err++;
                $display("FAIL simul_txn%0d got d=%b wr=%b addr=%h want d=%b wr=%b addr=%h",
                         k, o.dr, o.wr, o.addr, exp_q[k].is_d, exp_q[k].wr, exp_q[k].addr);
            end
            if (k > 0) begin
                n_cmp++;
                if (o.gap != 2) begin
                    n_err++; $display("FAIL simul_gap%0d got %0d want 2", k, o.gap);
                end
            end
        end
    endtask

    task automatic test_alternate();
        int start = obs.size();
        bit ok;
        mem_lat = $urandom_range(1, 4);
        for (int k = 0; k < 3; k++) begin
            dreq_t d;
            int kind = $urandom_range(0, 2);
            d.rd = (kind != 1); d.wr = (kind != 0);
            d.addr = $urandom; d.wdata = rand_line();
            d_q.push_back(d);
            i_q.push_back($urandom);
        end
        predict();
        drain(600, ok);
        n_cmp++;
        if (!ok || obs.size() - start != 6) begin
            n_err++; $display("FAIL alt_count got %0d want 6 (done=%0b)", obs.size() - start, ok);
        end
        foreach (exp_q[k]) if (start + k < obs.size()) begin
            obs_t o = obs[start + k];
            n_cmp++;
            if (o.dr !== exp_q[k].is_d || o.ir === exp_q[k].is_d || o.wr !== exp_q[k].wr ||
                o.rd === exp_q[k].wr || o.addr !== exp_q[k].addr ||
                (exp_q[k].wr ? o.wdata !== exp_q[k].wdata : o.rdata !== line_of(exp_q[k].addr))) begin
                n_err++;
                $display("FAIL alt_txn%0d got d=%b wr=%b addr=%h want d=%b wr=%b addr=%h",
                         k, o.dr, o.wr, o.addr, exp_q[k].is_d, exp_q[k].wr, exp_q[k].addr);
            end
            if (k > 0) begin
                n_cmp++;
                if (o.gap != 2 || o.cyc != mem_lat) begin
                    n_err++; $display("FAIL alt_timing%0d got gap=%0d len=%0d want gap=2 len=%0d", k, o.gap, o.cyc, mem_lat);
                end
            end
        end
    endtask

    task automatic test_stable();
        int start = obs.size();
        int se0 = stab_err;
        bit ok;
        dreq_t d;
        d.rd = 0; d.wr = 1; d.addr = $urandom; d.wdata = rand_line();
        mem_lat = 6;
        scramble = 1;
        d_q.push_back(d);
        predict();
        drain(200, ok);
        scramble = 0;
        n_cmp++;
        if (stab_err != se0) begin
            n_err++; $display("FAIL stable_window got %0d changes want 0", stab_err - se0);
        end
        n_cmp++;
        if (!ok || obs.size() - start != 1) begin
            n_err++; $display("FAIL stable_count got %0d want 1 (done=%0b)", obs.size() - start, ok);
        end else if (obs[start].addr !== d.addr || obs[start].wdata !== d.wdata || obs[start].wr !== 1'b1) begin
            n_err++; $display("FAIL stable_capture got addr=%h wdata=%h want addr=%h wdata=%h",
                              obs[start].addr, obs[start].wdata, d.addr, d.wdata);
        end
    endtask

    task automatic test_async_reset();
        int start = obs.size();
        int n = 0;
        bit ok;
        logic [31:0] a2 = $urandom;
        mem_lat = 10;
        i_q.push_back($urandom);
        while (!mem_read && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        n_cmp++;
        if (!mem_read) begin
            n_err++; $display("FAIL areset_start got mem_read=%b want 1 within 50 cycles", mem_read);
        end
        @(negedge clk);
        #3;
        i_drop = 1;
        rst = 0;
        #1;
        n_cmp++;
        if ({mem_read, mem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || mem_address !== 32'h0 || mem_wdata !== 256'h0) begin
            n_err++;
            $display("FAIL areset_outputs got rd/wr/iresp/dresp=%b addr=%h want 0000 addr=0",
                     {mem_read, mem_write, i_pmem_resp, d_pmem_resp}, mem_address);
        end
        repeat (2) @(negedge clk);
        i_drop = 0;
        #3 rst = 1;
        exp_last_d = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs.size() != start) begin
            n_err++; $display("FAIL areset_noresp got %0d resp want 0", obs.size() - start);
        end
        mem_lat = 3;
        i_q.push_back(a2);
        predict();
        drain(200, ok);
        n_cmp++;
        if (!ok || obs.size() - start != 1) begin
            n_err++; $display("FAIL areset_regrant got %0d resp want 1 (done=%0b)", obs.size() - start, ok);
        end else if (obs[start].ir !== 1'b1 || obs[start].addr !== a2 || obs[start].rdata !== line_of(a2)) begin
            n_err++; $display("FAIL areset_regrant got ir=%b addr=%h want ir=1 addr=%h", obs[start].ir, obs[start].addr, a2);
        end
    endtask

    task automatic test_rw_both();
        int start = obs.size();
        int rd0 = rd_cyc;
        bit ok;
        dreq_t d;
        d.rd = 1; d.wr = 1; d.addr = $urandom; d.wdata = rand_line();
        mem_lat = 4;
        d_q.push_back(d);
        predict();
        drain(200, ok);
        n_cmp++;
        if (rd_cyc != rd0) begin
            n_err++; $display("FAIL rwboth_noread got %0d read cycles want 0", rd_cyc - rd0);
        end
        n_cmp++;
        if (!ok || obs.size() - start != 1) begin
            n_err++; $display("FAIL rwboth_count got %0d resp want 1 (done=%0b)", obs.size() - start, ok);
        end else if (obs[start].dr !== 1'b1 || obs[start].wr !== 1'b1 || obs[start].wdata !== d.wdata) begin
            n_err++; $display("FAIL rwboth_txn got dr=%b wr=%b want dr=1 wr=1", obs[start].dr, obs[start].wr);
        end
    endtask

    initial begin
        rst = 0;
        test_reset();
        test_i_only();
        test_simultaneous();
        test_alternate();
        test_stable();
        test_async_reset();
        test_rw_both();
        n_cmp++;
        if (both_err != 0 || both_resp_err != 0 || spurious != 0) begin
            n_err++;
            $display("FAIL protocol got rw_both=%0d resp_both=%0d resp_no_mem=%0d want 0 0 0",
                     both_err, both_resp_err, spurious);
        end
        n_cmp++;
        if (stab_err != 0) begin
            n_err++; $display("FAIL addr_stable got %0d changes want 0", stab_err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
